// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS keying front end (rf_symbol_serializer).
package dds_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    SHIFT    = 2'd2
  } ser_state_t;

  localparam int unsigned BYTE_W        = 8;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'hAA;

endpackage

// File: rtl/sym_fifo.sv
// Synchronous payload FIFO (DEPTH x WIDTH) with registered occupancy and full/empty flags.
module sym_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push, pop;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign rd_data_o = mem_q[rd_ptr_q];

  // A write is refused while full even if a read frees a slot on the same edge.
  assign push = wr_en_i && !full_o;
  assign pop  = rd_en_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rf_symbol_serializer.sv
// Byte-to-symbol serializer feeding the DDS frequency-select/OOK input, MSB first.
// Optional burst preamble (8'hAA) enabled by defining RF_SER_PREAMBLE_EN.
module rf_symbol_serializer
  import dds_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DIV_W-1:0] sym_div,
  output logic             rf_data,
  output logic             sym_strobe,
  output logic             busy,
  output logic             burst_done
);

  ser_state_t        state_q, state_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  sym_cnt_q, sym_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic              strobe_q, strobe_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              fifo_full, fifo_empty, fifo_pop;
  logic [BYTE_W-1:0] fifo_rd_data;
  logic              sym_end;

  sym_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .wr_en_i   (s_valid),
    .wr_data_i (s_data),
    .rd_en_i   (fifo_pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign s_ready    = !fifo_full;
  // shreg is cleared on return to IDLE, so its MSB doubles as the registered rf_data.
  assign rf_data    = shreg_q[7];
  assign sym_strobe = strobe_q;
  assign busy       = busy_q;
  assign burst_done = done_q;

  assign sym_end = (sym_cnt_q == div_q - DIV_W'(1));

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    div_d     = div_q;
    sym_cnt_d = sym_cnt_q;
    bit_cnt_d = bit_cnt_q;
    busy_d    = busy_q;
    strobe_d  = 1'b0;
    done_d    = 1'b0;
    fifo_pop  = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (!fifo_empty) begin
          div_d     = (sym_div == '0) ? DIV_W'(1) : sym_div;
          bit_cnt_d = 3'd7;
          sym_cnt_d = '0;
          strobe_d  = 1'b1;
          busy_d    = 1'b1;
`ifdef RF_SER_PREAMBLE_EN
          shreg_d   = PREAMBLE_BYTE;
          state_d   = PREAMBLE;
`else
          fifo_pop  = 1'b1;
          shreg_d   = fifo_rd_data;
          state_d   = SHIFT;
`endif
        end
      end

      PREAMBLE, SHIFT: begin
        if (!sym_end) begin
          sym_cnt_d = sym_cnt_q + DIV_W'(1);
        end else begin
          sym_cnt_d = '0;
          if (bit_cnt_q != 3'd0) begin
            shreg_d   = {shreg_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q - 3'd1;
            strobe_d  = 1'b1;
          end else if (!fifo_empty) begin
            // Reload straight from the FIFO so consecutive bytes run gap-free.
            fifo_pop  = 1'b1;
            shreg_d   = fifo_rd_data;
            bit_cnt_d = 3'd7;
            strobe_d  = 1'b1;
            state_d   = SHIFT;
          end else begin
            shreg_d   = '0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            state_d   = IDLE;
          end
        end
      end

      default: begin
        shreg_d = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      div_q     <= DIV_W'(1);
      sym_cnt_q <= '0;
      bit_cnt_q <= '0;
      strobe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      div_q     <= div_d;
      sym_cnt_q <= sym_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      strobe_q  <= strobe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_rf_symbol_serializer.sv
// Scoreboard bench for rf_symbol_serializer; expected symbols come from the bytes sent.
module tb_rf_symbol_serializer;

  localparam int FD = 4;
  localparam int DW = 16;

  logic          clk;
  logic          rst;
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] sym_div;
  logic          rf_data;
  logic          sym_strobe;
  logic          busy;
  logic          burst_done;

  rf_symbol_serializer #(
    .FIFO_DEPTH (FD),
    .DIV_W      (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .sym_div    (sym_div),
    .rf_data    (rf_data),
    .sym_strobe (sym_strobe),
    .busy       (busy),
    .burst_done (burst_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit         exp_q[$];
  logic [7:0] tx[$];
  int         burst_div = 1;
  bit         active = 0;
  bit         cur_bit = 0;
  int         cur_len = 0;
  int         busy_cycles = 0;
  int         strobes = 0;
  int         dones = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, act, req, $time);
    end
  endtask

  task automatic push_byte_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
  endtask

  // Monitor: every strobe pops the next expected symbol; hold time checked at symbol end.
  always @(negedge clk) begin
    if (rst) begin
      if (busy) busy_cycles++;
      if (sym_strobe) begin
        if (active) chk("sym_len", cur_len, burst_div);
        if (exp_q.size() == 0) begin
          chk("exp_symbol_available", 0, 1);
        end else begin
          cur_bit = exp_q.pop_front();
          chk("rf_bit", rf_data, cur_bit);
        end
        strobes++;
        active  = 1;
        cur_len = 1;
      end else if (active && !busy) begin
        chk("sym_len_last", cur_len, burst_div);
        chk("rf_idle_zero", rf_data, 0);
        active = 0;
      end else if (active) begin
        cur_len++;
        if (rf_data != cur_bit) chk("rf_hold", rf_data, cur_bit);
      end
      if (burst_done) begin
        dones++;
        chk("done_queue_empty", exp_q.size(), 0);
        chk("done_busy_low", busy, 0);
      end
    end
  end

  task automatic drive_bytes(input bit check_full, input int new_div);
    int  accepts = 0;
    bit  stalled = 0;
    int  to;
    @(posedge clk);
    #1;
    foreach (tx[i]) begin
      s_valid = 1'b1;
      s_data  = tx[i];
      to = 0;
      forever begin
        @(negedge clk);
        if (s_ready) break;
        if (check_full && !stalled) chk("accepts_before_full", accepts, FD + 1);
        stalled = 1;
        to++;
        if (to > 20000) begin
          chk("push_timeout", 0, 1);
          s_valid = 1'b0;
          return;
        end
      end
      @(posedge clk);
      accepts++;
      #1;
      if (accepts == 2 && new_div >= 0) sym_div = DW'(new_div);
    end
    s_valid = 1'b0;
    if (check_full) chk("full_reached", stalled, 1);
  endtask

  task automatic send_burst(input int div, input int new_div, input bit check_full);
    int nbits = 0;
    int to = 0;
    sym_div     = DW'(div);
    burst_div   = (div == 0) ? 1 : div;
    busy_cycles = 0;
    strobes     = 0;
    dones       = 0;
`ifdef RF_SER_PREAMBLE_EN
    push_byte_bits(8'hAA);
    nbits += 8;
`endif
    foreach (tx[i]) begin
      push_byte_bits(tx[i]);
      nbits += 8;
    end
    drive_bytes(check_full, new_div);
    while (dones == 0 && to < 20000) begin
      @(posedge clk);
      to++;
    end
    chk("burst_done_seen", (dones > 0) ? 1 : 0, 1);
    repeat (4) @(posedge clk);
    chk("burst_done_count", dones, 1);
    chk("busy_cycles", busy_cycles, nbits * burst_div);
    chk("strobe_count", strobes, nbits);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    sym_div = DW'(1);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rf_data", rf_data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_strobe", sym_strobe, 0);
    chk("reset_done", burst_done, 0);
    chk("reset_s_ready", s_ready, 1);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    tx = '{8'hA5};
    send_burst(4, -1, 0);

    tx = '{8'hFF, 8'h00};
    send_burst(1, -1, 0);

    tx = '{8'h0F};
    send_burst(2, -1, 0);

    tx = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    send_burst(100, -1, 1);

    tx = '{8'hC3, 8'h3C};
    send_burst(0, -1, 0);

    tx = '{8'h81, 8'h7E, 8'hE7};
    send_burst(3, 7, 0);

    for (int n = 0; n < 8; n++) begin
      int len;
      len = int'($urandom_range(1, 5));
      tx.delete();
      for (int k = 0; k < len; k++) tx.push_back(8'($urandom));
      send_burst(int'($urandom_range(0, 5)), -1, 0);
    end

    // Reset in the middle of a burst with bytes still queued.
    tx = '{8'h11, 8'h22, 8'h33};
    sym_div   = DW'(4);
    burst_div = 4;
    foreach (tx[i]) push_byte_bits(tx[i]);
    drive_bytes(0, -1);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_rf_data", rf_data, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_s_ready", s_ready, 1);
    chk("midrst_done", burst_done, 0);
    exp_q.delete();
    active = 0;
    dones  = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    busy_cycles = 0;
    repeat (40) @(posedge clk);
    chk("post_rst_idle_busy", busy_cycles, 0);
    chk("post_rst_no_done", dones, 0);

    tx = '{8'h5A};
    send_burst(2, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
